// File: rtl/mem_dout_packer.sv
// Packs a narrow compute-result stream into full-width memory words for the AXI write master.
// Optional build macro MEM_DOUT_PACK_MSB_FIRST_EN selects MSB-first lane order (default LSB-first).
module mem_dout_packer #(
    parameter int C_IN_WIDTH   = 32,
    parameter int C_DATA_WIDTH = 128
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic                    I_ap_start,
    input  logic [31:0]             I_out_data_bytes,
    input  logic [C_IN_WIDTH-1:0]   I_din,
    input  logic                    I_din_valid,
    output logic                    O_din_ready,
    output logic [C_DATA_WIDTH-1:0] O_mem_dout,
    output logic                    O_mem_dout_valid,
    output logic                    O_done,
    output logic [31:0]             O_word_cnt
);

    localparam int R       = C_DATA_WIDTH / C_IN_WIDTH;
    localparam int B       = C_IN_WIDTH / 8;
    localparam int B_SHIFT = $clog2(B);
    localparam int LANE_W  = (R > 1) ? $clog2(R) : 1;

`ifdef MEM_DOUT_PACK_MSB_FIRST_EN
    localparam logic [LANE_W-1:0] LANE_FIRST = LANE_W'(R - 1);
    localparam logic [LANE_W-1:0] LANE_LAST  = '0;
    localparam bit                MSB_FIRST  = 1'b1;
`else
    localparam logic [LANE_W-1:0] LANE_FIRST = '0;
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(R - 1);
    localparam bit                MSB_FIRST  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic                    start_prev_reg;
    logic [LANE_W-1:0]       lane_reg, lane_next;
    logic [31:0]             remain_reg, remain_next;
    logic [C_DATA_WIDTH-1:0] shadow_reg, shadow_next;
    logic [C_DATA_WIDTH-1:0] dout_reg, dout_next;
    logic                    valid_reg, valid_next;
    logic [31:0]             cnt_reg, cnt_next;

    logic                    start_edge;
    logic [31:0]             n_in;
    logic [LANE_W-1:0]       lane_step;
    logic                    last_beat;
    logic [C_DATA_WIDTH-1:0] merged;

    assign start_edge = I_ap_start && !start_prev_reg;

    // Ceiling division by the beat size without needing a 33-bit intermediate.
    assign n_in = (I_out_data_bytes >> B_SHIFT)
                + {31'd0, ((I_out_data_bytes & 32'(B - 1)) != 32'd0)};

    assign lane_step = (lane_reg == LANE_LAST) ? LANE_FIRST
                     : (MSB_FIRST ? lane_reg - LANE_W'(1) : lane_reg + LANE_W'(1));

    assign last_beat = (remain_reg == 32'd1);

    // Shadow register with the current input beat dropped into the active lane.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lane
            assign merged[gi*C_IN_WIDTH +: C_IN_WIDTH] =
                (lane_reg == LANE_W'(gi)) ? I_din : shadow_reg[gi*C_IN_WIDTH +: C_IN_WIDTH];
        end
    endgenerate

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg      <= S_IDLE;
            start_prev_reg <= 1'b0;
            lane_reg       <= '0;
            remain_reg     <= '0;
            shadow_reg     <= '0;
            dout_reg       <= '0;
            valid_reg      <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= I_ap_start;
            lane_reg       <= lane_next;
            remain_reg     <= remain_next;
            shadow_reg     <= shadow_next;
            dout_reg       <= dout_next;
            valid_reg      <= valid_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        lane_next   = lane_reg;
        remain_next = remain_reg;
        shadow_next = shadow_reg;
        dout_next   = dout_reg;
        valid_next  = 1'b0;
        cnt_next    = cnt_reg;
        O_din_ready = (state_reg == S_PACK);
        O_done      = (state_reg == S_DONE);

        // A start edge wins in every state, aborting any partially packed word.
        if (start_edge) begin
            remain_next = n_in;
            lane_next   = LANE_FIRST;
            shadow_next = '0;
            cnt_next    = '0;
            state_next  = (n_in == 32'd0) ? S_DONE : S_PACK;
        end else begin
            case (state_reg)
                S_PACK: begin
                    if (I_din_valid) begin
                        remain_next = remain_reg - 32'd1;
                        lane_next   = lane_step;
                        if (lane_reg == LANE_LAST || last_beat) begin
                            dout_next   = merged;
                            valid_next  = 1'b1;
                            cnt_next    = cnt_reg + 32'd1;
                            shadow_next = '0;
                        end else begin
                            shadow_next = merged;
                        end
                        if (last_beat) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_IDLE:  state_next = S_IDLE;
                S_DONE:  state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign O_mem_dout       = dout_reg;
    assign O_mem_dout_valid = valid_reg;
    assign O_word_cnt       = cnt_reg;

endmodule

// File: tb/tb_mem_dout_packer.sv
// Scoreboard bench for mem_dout_packer: stimulus queues expected words, a monitor checks each strobe.
// Expected words follow the lane order of MEM_DOUT_PACK_MSB_FIRST_EN when defined.
module tb_mem_dout_packer;

    logic         I_clk;
    logic         I_rst_n;
    logic         I_ap_start;
    logic [31:0]  I_out_data_bytes;
    logic [31:0]  I_din;
    logic         I_din_valid;
    logic         O_din_ready;
    logic [127:0] O_mem_dout;
    logic         O_mem_dout_valid;
    logic         O_done;
    logic [31:0]  O_word_cnt;

    typedef struct {
        logic [127:0] data;
        logic [31:0]  cnt;
        logic         done;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mem_dout_packer #(.C_IN_WIDTH(32), .C_DATA_WIDTH(128)) dut (
        .I_clk            (I_clk),
        .I_rst_n          (I_rst_n),
        .I_ap_start       (I_ap_start),
        .I_out_data_bytes (I_out_data_bytes),
        .I_din            (I_din),
        .I_din_valid      (I_din_valid),
        .O_din_ready      (O_din_ready),
        .O_mem_dout       (O_mem_dout),
        .O_mem_dout_valid (O_mem_dout_valid),
        .O_done           (O_done),
        .O_word_cnt       (O_word_cnt)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    // a is the first beat of the word, d the last.
    function automatic logic [127:0] w4(input logic [31:0] a, b, c, d);
`ifdef MEM_DOUT_PACK_MSB_FIRST_EN
        return {a, b, c, d};
`else
        return {d, c, b, a};
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic start(input logic [31:0] bytes);
        I_out_data_bytes = bytes;
        I_ap_start       = 1'b1;
        @(posedge I_clk);
        #1;
        I_ap_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input bit push, input logic [127:0] w,
                        input logic [31:0] c, input bit dn);
        exp_t e;
        I_din       = d;
        I_din_valid = 1'b1;
        check("ready_at_beat", {127'd0, O_din_ready}, 128'd1);
        if (push) begin
            e.data = w;
            e.cnt  = c;
            e.done = dn;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge I_clk);
        #1;
        I_din_valid = 1'b0;
    endtask

    always @(negedge I_clk) begin
        exp_t e;
        if (O_mem_dout_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe actual=%h required=no strobe", O_mem_dout);
            end else begin
                e = q.pop_front();
                $display("word cnt=%0d data=%h done=%0b cyc=%0d", O_word_cnt, O_mem_dout, O_done, cyc);
                check("word_data", O_mem_dout, e.data);
                check("word_cnt", {96'd0, O_word_cnt}, {96'd0, e.cnt});
                check("word_done", {127'd0, O_done}, {127'd0, e.done});
                check("word_timing", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        I_rst_n = 1'b0; I_ap_start = 1'b0; I_out_data_bytes = '0; I_din = '0; I_din_valid = 1'b0;
        repeat (2) @(posedge I_clk);
        #1;
        check("rst_ready", {127'd0, O_din_ready}, 128'd0);
        check("rst_dout", O_mem_dout, 128'd0);
        check("rst_valid", {127'd0, O_mem_dout_valid}, 128'd0);
        check("rst_done", {127'd0, O_done}, 128'd0);
        check("rst_cnt", {96'd0, O_word_cnt}, 128'd0);
        I_rst_n = 1'b1;
        @(posedge I_clk);
        #1;

        // Four full words, continuous stream
        start(32'd64);
        check("t1_ready_after_start", {127'd0, O_din_ready}, 128'd1);
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] b0;
            b0 = 32'(i - 3);
            beat(32'(i), (i % 4) == 0, w4(b0, b0 + 1, b0 + 2, b0 + 3), 32'(i / 4), i == 16);
        end
        @(posedge I_clk);
        #1;
        check("t1_done", {127'd0, O_done}, 128'd1);
        check("t1_cnt", {96'd0, O_word_cnt}, 128'd4);
        check("t1_ready_low", {127'd0, O_din_ready}, 128'd0);

        // Partial final word, extra beat refused
        start(32'd24);
        check("t2_done_cleared", {127'd0, O_done}, 128'd0);
        beat(32'hA, 0, '0, 0, 0);
        beat(32'hB, 0, '0, 0, 0);
        beat(32'hC, 0, '0, 0, 0);
        beat(32'hD, 1, w4(32'hA, 32'hB, 32'hC, 32'hD), 32'd1, 0);
        beat(32'hE, 0, '0, 0, 0);
        beat(32'hF, 1, w4(32'hE, 32'hF, 32'h0, 32'h0), 32'd2, 1);
        check("t2_ready_low", {127'd0, O_din_ready}, 128'd0);
        I_din = 32'h77; I_din_valid = 1'b1;
        repeat (2) @(posedge I_clk);
        #1;
        I_din_valid = 1'b0;
        check("t2_cnt_after_extra", {96'd0, O_word_cnt}, 128'd2);
        check("t2_done", {127'd0, O_done}, 128'd1);

        // Zero length
        start(32'd0);
        check("t3_done", {127'd0, O_done}, 128'd1);
        check("t3_cnt", {96'd0, O_word_cnt}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_low", {127'd0, O_din_ready}, 128'd0);
            @(posedge I_clk);
            #1;
        end

        // Valid gaps: one beat then two idle cycles
        start(32'd32);
        for (int i = 1; i <= 8; i++) begin
            if (i <= 4)
                beat(32'h20 + 32'(i), i == 4, w4(32'h21, 32'h22, 32'h23, 32'h24), 32'd1, 0);
            else
                beat(32'h20 + 32'(i), i == 8, w4(32'h25, 32'h26, 32'h27, 32'h28), 32'd2, 1);
            repeat (2) @(posedge I_clk);
            #1;
        end

        // Byte count not a multiple of the beat size: 5 bytes -> 2 beats
        start(32'd5);
        beat(32'hDEADBEEF, 0, '0, 0, 0);
        beat(32'h12345678, 1, w4(32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0), 32'd1, 1);
        check("t5_ready_low", {127'd0, O_din_ready}, 128'd0);

        // Abort after two beats with a new start edge
        start(32'd64);
        beat(32'h51, 0, '0, 0, 0);
        beat(32'h52, 0, '0, 0, 0);
        start(32'd16);
        check("t6_done_low", {127'd0, O_done}, 128'd0);
        check("t6_cnt_cleared", {96'd0, O_word_cnt}, 128'd0);
        beat(32'h61, 0, '0, 0, 0);
        beat(32'h62, 0, '0, 0, 0);
        beat(32'h63, 0, '0, 0, 0);
        beat(32'h64, 1, w4(32'h61, 32'h62, 32'h63, 32'h64), 32'd1, 1);

        // Asynchronous reset mid-job
        start(32'd64);
        beat(32'h71, 0, '0, 0, 0);
        beat(32'h72, 0, '0, 0, 0);
        beat(32'h73, 0, '0, 0, 0);
        beat(32'h74, 1, w4(32'h71, 32'h72, 32'h73, 32'h74), 32'd1, 0);
        beat(32'h75, 0, '0, 0, 0);
        #2;
        I_rst_n = 1'b0;
        #1;
        check("arst_ready", {127'd0, O_din_ready}, 128'd0);
        check("arst_dout", O_mem_dout, 128'd0);
        check("arst_valid", {127'd0, O_mem_dout_valid}, 128'd0);
        check("arst_done", {127'd0, O_done}, 128'd0);
        check("arst_cnt", {96'd0, O_word_cnt}, 128'd0);
        @(posedge I_clk);
        #1;
        I_rst_n = 1'b1;
        repeat (2) @(posedge I_clk);
        #1;
        check("idle_ready", {127'd0, O_din_ready}, 128'd0);
        check("idle_done", {127'd0, O_done}, 128'd0);

        // Fresh job after reset
        start(32'd16);
        beat(32'h1, 0, '0, 0, 0);
        beat(32'h2, 0, '0, 0, 0);
        beat(32'h3, 0, '0, 0, 0);
        beat(32'h4, 1, w4(32'h1, 32'h2, 32'h3, 32'h4), 32'd1, 1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge I_clk);
        @(negedge I_clk);
        check("queue_empty", 128'(q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
